// File: rtl/usart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// usart_tx_arbiter
//
// Shares one USART transmitter between two byte-stream requesters. A
// requester is granted the transmitter for a whole message (ended by its
// last flag) or until BURST_MAX bytes have gone out, whichever is first.
// Each byte is written to UDR when UDRE is set; end of message is reported
// once TXC says the final frame has left the shift register.
//
// Ports
//   i_fosk        system clock, rising edge
//   i_rst         asynchronous reset, active high
//   i_TXEN        transmitter enable; low drops the grant
//   i_req[1:0]    requester n has a byte available
//   i_data0/1     requester byte {tx8, udr[7:0]}
//   i_last[1:0]   requester n's current byte ends its message
//   i_udre        UDR-empty flag from the transmitter
//   i_txc         transmit-complete pulse from the transmitter
//   o_grant[1:0]  one-hot current owner, 00 when idle
//   o_ack[1:0]    requester n's byte consumed (1 cycle)
//   o_done[1:0]   requester n's message fully on the line (1 cycle)
//   o_we_udr_tr   UDR write strobe
//   o_udr, o_tx8  byte and 9th bit presented to the transmitter
// ---------------------------------------------------------------------------
module usart_tx_arbiter #(
   parameter int BURST_MAX = 16
) (
   input  logic       i_fosk,
   input  logic       i_rst,
   input  logic       i_TXEN,
   input  logic [1:0] i_req,
   input  logic [8:0] i_data0,
   input  logic [8:0] i_data1,
   input  logic [1:0] i_last,
   input  logic       i_udre,
   input  logic       i_txc,
   output logic [1:0] o_grant,
   output logic [1:0] o_ack,
   output logic [1:0] o_done,
   output logic       o_we_udr_tr,
   output logic [7:0] o_udr,
   output logic       o_tx8
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SEND  = 3'd1;
   localparam logic [2:0] LOAD  = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   localparam logic [8:0] BURST_LIM = 9'(BURST_MAX);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       own;
   logic       prev_owner;
   logic [7:0] cnt;
   logic [9:0] hold;
   logic [1:0] done_q;

   logic [1:0] own_oh;
   logic       req_own;
   logic       last_own;
   logic [8:0] data_own;
   logic       pick_own;
   logic       burst_end;

   assign own_oh   = own ? 2'b10 : 2'b01;
   assign req_own  = own ? i_req[1]  : i_req[0];
   assign last_own = own ? i_last[1] : i_last[0];
   assign data_own = own ? i_data1   : i_data0;

   // On a tie the requester that did not own last time wins; with a single
   // requester it simply gets the grant.
   assign pick_own = (&i_req) ? ~prev_owner : i_req[1];

   // cnt holds the bytes already written in this grant, before the current one.
   assign burst_end = ({1'b0, cnt} + 9'd1) == BURST_LIM;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_TXEN && (|i_req)) state_nxt = SEND;
         SEND: begin
            if (!i_TXEN)                state_nxt = IDLE;
            else if (req_own && i_udre) state_nxt = LOAD;
         end
         LOAD: begin
            if (!i_TXEN)        state_nxt = IDLE;
            else if (hold[9])   state_nxt = DRAIN;
            else if (burst_end) state_nxt = IDLE;
            else                state_nxt = GAP;
         end
         // One dead cycle so the transmitter can drop UDRE after the write.
         GAP:     state_nxt = i_TXEN ? SEND : IDLE;
         DRAIN:   if (!i_TXEN || i_txc) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_fosk or posedge i_rst) begin
      if (i_rst) begin
         state      <= IDLE;
         own        <= 1'b0;
         prev_owner <= 1'b1;
         cnt        <= 8'd0;
         hold       <= 10'd0;
         done_q     <= 2'b00;
      end else begin
         state  <= state_nxt;
         done_q <= 2'b00;
         case (state)
            IDLE: begin
               if (state_nxt == SEND) own <= pick_own;
            end
            SEND: begin
               if (state_nxt == LOAD) hold <= {last_own, data_own};
            end
            LOAD: begin
               cnt <= cnt + 8'd1;
               // Forced release: the owner steps aside without a done pulse.
               if (i_TXEN && !hold[9] && burst_end) prev_owner <= own;
            end
            DRAIN: begin
               if (i_TXEN && i_txc) begin
                  done_q     <= own_oh;
                  prev_owner <= own;
               end
            end
            default: ;
         endcase
         if (state_nxt == IDLE) cnt <= 8'd0;
      end
   end

   assign o_grant     = (state == IDLE) ? 2'b00 : own_oh;
   assign o_ack       = (state == LOAD) ? own_oh : 2'b00;
   assign o_we_udr_tr = (state == LOAD);
   assign o_udr       = hold[7:0];
   assign o_tx8       = hold[8];
   assign o_done      = done_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_usart_tx_arbiter
//
// Bench for usart_tx_arbiter (BURST_MAX = 4). Each requester is modelled as
// a queue of {last, tx8, udr} bytes that advances on o_ack; the transmitter
// is modelled by a UDRE source and a TXC pulse a few cycles after the last
// byte of a message is written. Directed scenarios plus randomized message
// sets compared against a message-level arbitration model.
// ---------------------------------------------------------------------------
module tb_usart_tx_arbiter;

   localparam int BMAX = 4;

   logic       i_fosk = 1'b0;
   logic       i_rst;
   logic       i_TXEN;
   logic [1:0] i_req;
   logic [8:0] i_data0;
   logic [8:0] i_data1;
   logic [1:0] i_last;
   logic       i_udre;
   logic       i_txc;
   logic [1:0] o_grant;
   logic [1:0] o_ack;
   logic [1:0] o_done;
   logic       o_we_udr_tr;
   logic [7:0] o_udr;
   logic       o_tx8;

   always #5 i_fosk = ~i_fosk;

   usart_tx_arbiter #(.BURST_MAX(BMAX)) dut (
      .i_fosk      (i_fosk),
      .i_rst       (i_rst),
      .i_TXEN      (i_TXEN),
      .i_req       (i_req),
      .i_data0     (i_data0),
      .i_data1     (i_data1),
      .i_last      (i_last),
      .i_udre      (i_udre),
      .i_txc       (i_txc),
      .o_grant     (o_grant),
      .o_ack       (o_ack),
      .o_done      (o_done),
      .o_we_udr_tr (o_we_udr_tr),
      .o_udr       (o_udr),
      .o_tx8       (o_tx8)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [9:0]  q0[$];        // requester 0 bytes {last, tx8, udr}
   logic [9:0]  q1[$];
   logic [12:0] wr_log[$];    // {ack, grant, tx8, udr} at each write strobe
   int          wr_cyc[$];
   logic [2:0]  done_log[$];  // {done, txc seen in the previous cycle}
   bit          drv_en;
   bit          auto_txc;
   bit          auto_udre;
   int          txc_cnt;

   // One clock: sample outputs just after the edge, then update the
   // requester and transmitter models for the coming cycle.
   task automatic tick();
      logic [9:0] popped;
      @(posedge i_fosk);
      #1;
      cyc++;
      if (o_we_udr_tr) begin
         wr_log.push_back({o_ack, o_grant, o_tx8, o_udr});
         wr_cyc.push_back(cyc);
      end
      if (o_done != 2'b00) done_log.push_back({o_done, i_txc});
      if (auto_txc) begin
         i_txc = 1'b0;
         if (txc_cnt > 0) begin
            txc_cnt--;
            if (txc_cnt == 0) i_txc = 1'b1;
         end
      end
      if (drv_en) begin
         if (o_ack[0] && q0.size() > 0) begin
            popped = q0.pop_front();
            if (popped[9]) txc_cnt = $urandom_range(1, 4);
         end
         if (o_ack[1] && q1.size() > 0) begin
            popped = q1.pop_front();
            if (popped[9]) txc_cnt = $urandom_range(1, 4);
         end
         i_req   = {q1.size() != 0, q0.size() != 0};
         i_data0 = (q0.size() != 0) ? q0[0][8:0] : 9'h000;
         i_data1 = (q1.size() != 0) ? q1[0][8:0] : 9'h000;
         i_last  = {(q1.size() != 0) ? q1[0][9] : 1'b0,
                    (q0.size() != 0) ? q0[0][9] : 1'b0};
      end
      if (auto_udre) i_udre = ($urandom_range(0, 3) != 0);
   endtask

   task automatic do_reset();
      #2;
      i_rst     = 1'b1;
      drv_en    = 1'b1;
      auto_txc  = 1'b1;
      auto_udre = 1'b0;
      i_TXEN    = 1'b1;
      i_udre    = 1'b1;
      i_req     = 2'b00;
      i_data0   = 9'h000;
      i_data1   = 9'h000;
      i_last    = 2'b00;
      i_txc     = 1'b0;
      txc_cnt   = 0;
      q0.delete();
      q1.delete();
      wr_log.delete();
      wr_cyc.delete();
      done_log.delete();
      repeat (2) @(posedge i_fosk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      i_rst   = 1'b1;
      i_TXEN  = 1'b1;
      i_req   = 2'b11;
      i_data0 = 9'h1FF;
      i_data1 = 9'h1FF;
      i_last  = 2'b11;
      i_udre  = 1'b1;
      i_txc   = 1'b1;
      repeat (3) @(posedge i_fosk);
      #1;
      total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b want=00", o_grant); end
      total++; if (o_ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b want=00", o_ack); end
      total++; if (o_done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b want=00", o_done); end
      total++; if (o_we_udr_tr !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", o_we_udr_tr); end
      total++; if (o_udr !== 8'h00) begin bad++; $display("FAIL rst_udr got=%h want=00", o_udr); end
      total++; if (o_tx8 !== 1'b0) begin bad++; $display("FAIL rst_tx8 got=%b want=0", o_tx8); end
   endtask

   task automatic test_single_req();
      logic [8:0] exp_d [3];
      int k;
      exp_d[0] = 9'h011; exp_d[1] = 9'h022; exp_d[2] = 9'h033;
      do_reset();
      q0.push_back(10'h011);
      q0.push_back(10'h022);
      q0.push_back(10'h233);
      tick();
      k = cyc;
      repeat (24) tick();
      total++; if (wr_log.size() != 3) begin bad++; $display("FAIL single_nwr got=%0d want=3", wr_log.size()); end
      for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
         total++; if (wr_log[i][8:0] !== exp_d[i]) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", i, wr_log[i][8:0], exp_d[i]); end
         total++; if (wr_log[i][12:9] !== 4'b0101) begin bad++; $display("FAIL single_ackgrant[%0d] got=%b want=0101", i, wr_log[i][12:9]); end
         total++; if (wr_cyc[i] != k + 2 + 3 * i) begin bad++; $display("FAIL single_cycle[%0d] got=%0d want=%0d", i, wr_cyc[i], k + 2 + 3 * i); end
      end
      total++; if (done_log.size() != 1) begin bad++; $display("FAIL single_ndone got=%0d want=1", done_log.size()); end
      if (done_log.size() > 0) begin
         total++; if (done_log[0] !== 3'b011) begin bad++; $display("FAIL single_done got=%b want=011", done_log[0]); end
      end
      total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL single_idle_grant got=%b want=00", o_grant); end
   endtask

   task automatic test_contention();
      logic [10:0] exp_w [4];   // {grant, tx8, udr}
      logic [2:0]  exp_dn [4];
      exp_w[0] = {2'b01, 9'h0A0}; exp_w[1] = {2'b10, 9'h0B0};
      exp_w[2] = {2'b01, 9'h0A1}; exp_w[3] = {2'b10, 9'h0B1};
      exp_dn[0] = 3'b011; exp_dn[1] = 3'b101; exp_dn[2] = 3'b011; exp_dn[3] = 3'b101;
      do_reset();
      q0.push_back(10'h2A0); q0.push_back(10'h2A1);
      q1.push_back(10'h2B0); q1.push_back(10'h2B1);
      repeat (60) tick();
      total++; if (wr_log.size() != 4) begin bad++; $display("FAIL cont_nwr got=%0d want=4", wr_log.size()); end
      for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
         total++; if (wr_log[i][10:0] !== exp_w[i]) begin bad++; $display("FAIL cont_wr[%0d] got=%h want=%h", i, wr_log[i][10:0], exp_w[i]); end
      end
      total++; if (done_log.size() != 4) begin bad++; $display("FAIL cont_ndone got=%0d want=4", done_log.size()); end
      for (int i = 0; i < 4 && i < done_log.size(); i++) begin
         total++; if (done_log[i] !== exp_dn[i]) begin bad++; $display("FAIL cont_done[%0d] got=%b want=%b", i, done_log[i], exp_dn[i]); end
      end
   endtask

   task automatic test_burst_release();
      logic [10:0] exp_w [7];
      for (int i = 0; i < 4; i++) exp_w[i] = {2'b10, 9'h0C1 + 9'(i)};
      exp_w[4] = {2'b01, 9'h0D0};
      exp_w[5] = {2'b10, 9'h0C5};
      exp_w[6] = {2'b10, 9'h0C6};
      do_reset();
      for (int i = 1; i <= 5; i++) q1.push_back(10'h0C0 + 10'(i));
      q1.push_back(10'h2C6);
      for (int n = 0; n < 10 && wr_log.size() == 0; n++) tick();
      q0.push_back(10'h2D0);
      repeat (60) tick();
      total++; if (wr_log.size() != 7) begin bad++; $display("FAIL burst_nwr got=%0d want=7", wr_log.size()); end
      for (int i = 0; i < 7 && i < wr_log.size(); i++) begin
         total++; if (wr_log[i][10:0] !== exp_w[i]) begin bad++; $display("FAIL burst_wr[%0d] got=%h want=%h", i, wr_log[i][10:0], exp_w[i]); end
      end
      total++; if (done_log.size() != 2) begin bad++; $display("FAIL burst_ndone got=%0d want=2", done_log.size()); end
      if (done_log.size() >= 2) begin
         total++; if (done_log[0] !== 3'b011) begin bad++; $display("FAIL burst_done0 got=%b want=011", done_log[0]); end
         total++; if (done_log[1] !== 3'b101) begin bad++; $display("FAIL burst_done1 got=%b want=101", done_log[1]); end
      end
   endtask

   task automatic test_udre_stall();
      int k;
      do_reset();
      i_udre = 1'b0;
      q0.push_back(10'h27E);
      repeat (22) tick();
      total++; if (wr_log.size() != 0) begin bad++; $display("FAIL udre_early_wr got=%0d want=0", wr_log.size()); end
      total++; if (o_grant !== 2'b01) begin bad++; $display("FAIL udre_grant_held got=%b want=01", o_grant); end
      i_udre = 1'b1;
      k = cyc;
      repeat (6) tick();
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL udre_nwr got=%0d want=1", wr_log.size()); end
      if (wr_cyc.size() > 0) begin
         total++;
         if (wr_cyc[0] < k + 1 || wr_cyc[0] > k + 2) begin
            bad++; $display("FAIL udre_latency got=%0d want=%0d..%0d", wr_cyc[0], k + 1, k + 2);
         end
         total++; if (wr_log[0][8:0] !== 9'h07E) begin bad++; $display("FAIL udre_data got=%h want=07e", wr_log[0][8:0]); end
      end
   endtask

   task automatic test_tx8();
      do_reset();
      q1.push_back(10'h3A5);
      repeat (14) tick();
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL tx8_nwr got=%0d want=1", wr_log.size()); end
      if (wr_log.size() > 0) begin
         total++; if (wr_log[0][8] !== 1'b1) begin bad++; $display("FAIL tx8_bit got=%b want=1", wr_log[0][8]); end
         total++; if (wr_log[0][7:0] !== 8'hA5) begin bad++; $display("FAIL tx8_udr got=%h want=a5", wr_log[0][7:0]); end
         total++; if (wr_log[0][12:9] !== 4'b1010) begin bad++; $display("FAIL tx8_ackgrant got=%b want=1010", wr_log[0][12:9]); end
      end
   endtask

   task automatic test_txen_drain();
      do_reset();
      auto_txc = 1'b0;
      q0.push_back(10'h255);
      repeat (6) tick();
      total++; if (o_grant !== 2'b01) begin bad++; $display("FAIL drain_grant got=%b want=01", o_grant); end
      i_TXEN = 1'b0;
      tick();
      total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL txen_grant got=%b want=00", o_grant); end
      i_txc = 1'b1;
      tick();
      i_txc = 1'b0;
      repeat (4) tick();
      total++; if (done_log.size() != 0) begin bad++; $display("FAIL txen_done got=%0d want=0", done_log.size()); end
      total++; if ({o_ack, o_done, o_we_udr_tr} !== 5'b0) begin bad++; $display("FAIL txen_outs got=%b want=00000", {o_ack, o_done, o_we_udr_tr}); end
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL txen_nwr got=%0d want=1", wr_log.size()); end
      i_TXEN = 1'b1;
      tick();
   endtask

   task automatic test_rst_gap();
      do_reset();
      q0.push_back(10'h011);
      q0.push_back(10'h022);
      q0.push_back(10'h233);
      for (int n = 0; n < 10 && wr_log.size() == 0; n++) tick();
      tick();
      total++; if ({o_grant, o_we_udr_tr} !== 3'b010) begin bad++; $display("FAIL gap_state got=%b want=010", {o_grant, o_we_udr_tr}); end
      #2;
      i_rst = 1'b1;
      q0.delete();
      i_req = 2'b00;
      #1;
      total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL gaprst_grant got=%b want=00", o_grant); end
      total++; if ({o_ack, o_done, o_we_udr_tr} !== 5'b0) begin bad++; $display("FAIL gaprst_ctl got=%b want=00000", {o_ack, o_done, o_we_udr_tr}); end
      total++; if ({o_tx8, o_udr} !== 9'h000) begin bad++; $display("FAIL gaprst_data got=%h want=000", {o_tx8, o_udr}); end
      @(posedge i_fosk);
      #1;
      i_rst = 1'b0;
      repeat (5) tick();
      total++; if (done_log.size() != 0) begin bad++; $display("FAIL gaprst_done got=%0d want=0", done_log.size()); end
      total++; if (wr_log.size() != 1) begin bad++; $display("FAIL gaprst_nwr got=%0d want=1", wr_log.size()); end
   endtask

   // Random message sets; expected order comes from message-level
   // round-robin with a byte cap per grant.
   task automatic test_random(input int round);
      logic [9:0] m0[$];
      logic [9:0] m1[$];
      logic [9:0] exp_wr[$];
      bit         exp_dn[$];
      bit         prev;
      bit         own;
      int         nb;
      int         n;
      logic [9:0] b;
      logic [1:0] oh;
      do_reset();
      auto_udre = 1'b1;
      for (int r = 0; r < 2; r++) begin
         int nmsg;
         nmsg = $urandom_range(2, 4);
         for (int m = 0; m < nmsg; m++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) begin
               b = {(j == len - 1), 9'($urandom)};
               if (r == 0) q0.push_back(b); else q1.push_back(b);
            end
         end
      end
      m0 = q0;
      m1 = q1;
      prev = 1'b1;
      while (m0.size() > 0 || m1.size() > 0) begin
         if (m0.size() > 0 && m1.size() > 0) own = ~prev;
         else own = (m1.size() > 0);
         nb = 0;
         while (1) begin
            if (own) b = m1.pop_front(); else b = m0.pop_front();
            exp_wr.push_back({own, b[8:0]});
            nb++;
            if (b[9]) begin exp_dn.push_back(own); break; end
            if (nb == BMAX) break;
         end
         prev = own;
      end
      n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && done_log.size() >= exp_dn.size()) && n < 3000) begin
         tick();
         n++;
      end
      repeat (3) tick();
      total++; if (n >= 3000) begin bad++; $display("FAIL rnd%0d_timeout got=%0d want<3000", round, n); end
      total++; if (wr_log.size() != exp_wr.size()) begin bad++; $display("FAIL rnd%0d_nwr got=%0d want=%0d", round, wr_log.size(), exp_wr.size()); end
      for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
         oh = exp_wr[i][9] ? 2'b10 : 2'b01;
         total++;
         if (wr_log[i] !== {oh, oh, exp_wr[i][8:0]}) begin
            bad++; $display("FAIL rnd%0d_wr[%0d] got=%h want=%h", round, i, wr_log[i], {oh, oh, exp_wr[i][8:0]});
         end
         if (i > 0) begin
            total++; if (wr_cyc[i] - wr_cyc[i-1] < 3) begin bad++; $display("FAIL rnd%0d_spacing[%0d] got=%0d want>=3", round, i, wr_cyc[i] - wr_cyc[i-1]); end
         end
      end
      total++; if (done_log.size() != exp_dn.size()) begin bad++; $display("FAIL rnd%0d_ndone got=%0d want=%0d", round, done_log.size(), exp_dn.size()); end
      for (int i = 0; i < exp_dn.size() && i < done_log.size(); i++) begin
         oh = exp_dn[i] ? 2'b10 : 2'b01;
         total++; if (done_log[i] !== {oh, 1'b1}) begin bad++; $display("FAIL rnd%0d_done[%0d] got=%b want=%b", round, i, done_log[i], {oh, 1'b1}); end
      end
   endtask

   initial begin
      drv_en    = 1'b0;
      auto_txc  = 1'b0;
      auto_udre = 1'b0;
      txc_cnt   = 0;
      test_reset();
      test_single_req();
      test_contention();
      test_burst_release();
      test_udre_stall();
      test_tx8();
      test_txen_drain();
      test_rst_gap();
      for (int r = 0; r < 3; r++) test_random(r);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usart_tx_arbiter.md
# usart_tx_arbiter

Sequencer and round-robin arbiter that shares one USART transmitter between two byte-stream requesters. It grants the transmitter to one requester for a whole message, terminated by a `last` flag or forced out after `BURST_MAX` bytes. It feeds each byte into UDR when UDRE is set, and reports end-of-message once the final frame has left the shift register (TXC). It sits between the requester logic and the transmitter's `i_we_udr_tr` / `i_udr` / `i_tx8` inputs.

## Interface
- `BURST_MAX`, default 16: max bytes per grant before forced release. Legal range 1..255.
- `i_fosk` in 1: system clock, all logic on rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_TXEN` in 1: transmitter enable. Low releases the grant and returns to IDLE.
- `i_req` in 2: per-requester valid; bit n = requester n has a byte.
- `i_data0` in 9: requester 0 byte, `{tx8, udr[7:0]}`.
- `i_data1` in 9: requester 1 byte, `{tx8, udr[7:0]}`.
- `i_last` in 2: bit n = current byte of requester n ends its message.
- `i_udre` in 1: UDRE flag from the transmitter.
- `i_txc` in 1: TXC flag from the transmitter, frame-complete pulse.
- `o_grant` out 2: one-hot current owner; 00 when idle.
- `o_ack` out 2: one-cycle pulse; requester n's byte is consumed.
- `o_done` out 2: one-cycle pulse; requester n's message has fully left TxD.
- `o_we_udr_tr` out 1: UDR write strobe to the transmitter.
- `o_udr` out 8: byte to the transmitter.
- `o_tx8` out 1: 9th data bit to the transmitter.

## Operation
- States: IDLE, SEND, LOAD, GAP, DRAIN. State, hold register, counter and pointer are flops.
- Internal registers:
  - `hold[9:0]` = {last, tx8, udr}.
  - `cnt` is 8 bits.
  - `prev_owner` is 1 bit.
- IDLE:
  - `o_grant` = 00 and `cnt` = 0.
  - If `i_TXEN` and any `i_req`: grant one requester and go to SEND. If only one requests, grant it. If both request, grant `~prev_owner`.
- SEND:
  - If `!i_TXEN`: go to IDLE.
  - Else if `i_req[own] & i_udre`: latch `{i_last[own], i_data_own}` into `hold` and go to LOAD.
  - Otherwise stay in SEND; the grant is kept even if the owner's `i_req` drops.
- LOAD (exactly 1 cycle):
  - `o_we_udr_tr` = 1, `o_udr` = `hold[7:0]`, `o_tx8` = `hold[8]`, `o_ack[own]` = 1.
  - `cnt` increments.
  - Next state: if `hold[9]`, go to DRAIN. Else if `cnt+1 == BURST_MAX`, go to IDLE, setting `prev_owner` = own. Else go to GAP.
- GAP: 1 cycle, then SEND. This lets the transmitter clear UDRE after the write.
- DRAIN:
  - Wait for `i_txc`. On it: pulse `o_done[own]`, set `prev_owner` = own, go to IDLE.
  - If `!i_TXEN`: go to IDLE with no `o_done`.
- Forced release (BURST_MAX reached) gives no `o_done`. The requester's message resumes on its next grant.
- Handshake rule: a requester holds `i_data*` and `i_last` stable while `i_req` is high, until it sees `o_ack`.
- `o_udr` and `o_tx8` are driven from `hold` continuously. They are only meaningful while `o_we_udr_tr` = 1.

## Timing
- Reset values:
  - State IDLE; `o_grant` = 00; `o_ack` = `o_done` = 00.
  - `o_we_udr_tr` = 0; `o_udr` = 0x00; `o_tx8` = 0.
  - `hold` = 0; `cnt` = 0; `prev_owner` = 1, so requester 0 wins the first tie.
- Reset mid-message: everything returns to reset values immediately (asynchronous). No `o_done`.
- `o_grant` is asserted the cycle after the IDLE decision.
- First `o_we_udr_tr` comes at earliest 2 cycles after `i_req` rises with `i_udre` = 1: IDLE, then SEND, then LOAD.
- Byte throughput: at most 1 byte per 3 cycles (SEND, LOAD, GAP). In practice it is limited by UDRE.
- `o_ack` and `o_we_udr_tr` are coincident and exactly 1 cycle wide.
- `o_done` is asserted the cycle after `i_txc` is sampled high in DRAIN, for 1 cycle.
- `i_txc` outside DRAIN is ignored.
- `i_TXEN` falling takes effect on the next edge in any state. A write already in LOAD still completes that cycle.
- Grants alternate strictly under continuous contention. An idle gap of ≥1 cycle (IDLE) separates owners.

## Test plan
- Reset, then req0 alone sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33), `i_udre` = 1 → three `o_we_udr_tr` pulses 3 cycles apart with matching `o_udr`; three `o_ack[0]` pulses; `o_done[0]` one cycle after `i_txc`.
- Both `i_req` high from reset, single-byte messages, `i_txc` returned promptly → grants go 01, 10, 01, 10; `o_udr` alternates between requester data.
- `BURST_MAX` = 4, req1 sends 6 bytes with no last while req0 waits → 4 writes from req1; grant moves to req0 with no `o_done[1]`; req1 finishes later.
- `i_udre` held low 20 cycles in SEND → no write and grant held; `i_udre` rising → write 2 cycles later.
- Data 9-bit 0x1A5 → `o_tx8` = 1, `o_udr` = 0xA5 during the strobe.
- `i_TXEN` dropped in DRAIN, and separately `i_rst` pulsed in GAP → IDLE, outputs at reset values, no `o_done`.
